// File: rtl/lut_cfg_seq.sv
// lut_cfg_seq -- configuration sequencer for the per-PE LUT config bus.
//
// Accepts burst commands (base address + word count) with a streamed data
// port, and single host writes. Both sources are arbitrated onto one
// registered write bus (cfg_en/cfg_a/cfg_d). The host has fixed priority
// over burst commands while idle.
//
// Optional feature macro: LUT_CFG_SEQ_BOUND_EN
//   When defined, commands whose last address exceeds MaxAddr, and host
//   writes above MaxAddr, are accepted but dropped with a one-cycle err
//   pulse. When undefined, no check is made, addresses wrap, and err
//   stays 0.
//
// Ports:
//   cfg_clk, cfg_rst           clock, synchronous active-high reset
//   cmd_valid/ready/addr/len   burst command (len = word count - 1)
//   wr_valid/ready/data        burst data stream
//   hst_valid/ready/addr/data  single host write
//   cfg_en, cfg_a, cfg_d       registered config write bus
//   busy                       state is not IDLE
//   done                       one-cycle pulse on burst completion
//   err                        one-cycle pulse on rejected request
module lut_cfg_seq #(
  parameter int unsigned CfgDataWidth = 32,
  parameter int unsigned CfgAddrWidth = 8,
  parameter int unsigned LenWidth     = 4,
  parameter int unsigned MaxAddr      = 3
) (
  input  logic                    cfg_clk,
  input  logic                    cfg_rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [CfgAddrWidth-1:0] cmd_addr,
  input  logic [LenWidth-1:0]     cmd_len,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [CfgDataWidth-1:0] wr_data,
  input  logic                    hst_valid,
  output logic                    hst_ready,
  input  logic [CfgAddrWidth-1:0] hst_addr,
  input  logic [CfgDataWidth-1:0] hst_data,
  output logic                    cfg_en,
  output logic [CfgAddrWidth-1:0] cfg_a,
  output logic [CfgDataWidth-1:0] cfg_d,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

`ifdef LUT_CFG_SEQ_BOUND_EN
  localparam bit BoundEn = 1'b1;
`else
  localparam bit BoundEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [CfgAddrWidth-1:0] addr_q, addr_d;
  logic [LenWidth:0]       remain_q, remain_d;
  logic                    cfg_en_q, cfg_en_d;
  logic [CfgAddrWidth-1:0] cfg_a_q, cfg_a_d;
  logic [CfgDataWidth-1:0] cfg_d_q, cfg_d_d;
  logic                    err_q, err_d;

  logic                    hst_fire, cmd_fire, wr_fire;
  logic [31:0]             cmd_end;
  logic                    cmd_bad, hst_bad;

  // Readies are held low while reset is asserted so they first rise in the
  // cycle after reset is released.
  always_comb begin
    hst_ready = 1'b0;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    if (!cfg_rst) begin
      unique case (state_q)
        IDLE: begin
          hst_ready = 1'b1;
          cmd_ready = ~hst_valid;
        end
        BURST:   wr_ready = 1'b1;
        default: ;
      endcase
    end
  end

  assign hst_fire = hst_valid & hst_ready;
  assign cmd_fire = cmd_valid & cmd_ready;
  assign wr_fire  = wr_valid & wr_ready;

  // Bound check is done at 32 bits so base + len cannot wrap before compare.
  assign cmd_end = 32'(cmd_addr) + 32'(cmd_len);
  assign cmd_bad = BoundEn && (cmd_end > MaxAddr);
  assign hst_bad = BoundEn && (32'(hst_addr) > MaxAddr);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    cfg_en_d = 1'b0;
    cfg_a_d  = cfg_a_q;
    cfg_d_d  = cfg_d_q;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hst_fire) begin
          if (hst_bad) begin
            err_d = 1'b1;
          end else begin
            cfg_en_d = 1'b1;
            cfg_a_d  = hst_addr;
            cfg_d_d  = hst_data;
          end
        end else if (cmd_fire) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            addr_d   = cmd_addr;
            remain_d = {1'b0, cmd_len} + (LenWidth+1)'(1);
            state_d  = BURST;
          end
        end
      end
      BURST: begin
        if (wr_fire) begin
          cfg_en_d = 1'b1;
          cfg_a_d  = addr_q;
          cfg_d_d  = wr_data;
          addr_d   = addr_q + CfgAddrWidth'(1);
          remain_d = remain_q - (LenWidth+1)'(1);
          if (remain_q == (LenWidth+1)'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cfg_clk) begin
    if (cfg_rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      cfg_en_q <= 1'b0;
      cfg_a_q  <= '0;
      cfg_d_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      cfg_en_q <= cfg_en_d;
      cfg_a_q  <= cfg_a_d;
      cfg_d_q  <= cfg_d_d;
      err_q    <= err_d;
    end
  end

  assign cfg_en = cfg_en_q;
  assign cfg_a  = cfg_a_q;
  assign cfg_d  = cfg_d_q;
  assign err    = err_q;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);

endmodule
